// File: rtl/demux1x8_driver_if.sv
// Upstream bit handshake into the 1x8 demux driver: valid/ready plus the bit,
// its explicit channel and the explicit-mode select.
interface demux1x8_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [2:0] in_chan;
  logic       explicit;

  modport master (output in_valid, output in_bit, output in_chan, output explicit, input in_ready);
  modport slave  (input in_valid, input in_bit, input in_chan, input explicit, output in_ready);
endinterface

// File: rtl/demux1x8_driver.sv
// Sequencer for a 1x8 demux: holds each accepted bit on D/S for DWELL cycles,
// then idles GAP cycles; auto mode walks channels 0..7 and counts frames.
module demux1x8_driver #(
  parameter int DWELL = 2,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  demux1x8_driver_if.slave   up,
  input  logic               clr_frame,
  output logic               D,
  output logic [2:0]         S,
  output logic               out_valid,
  output logic               frame_done,
  output logic [7:0]         frame_cnt
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [DCW-1:0] DWELL_LOAD = DCW'(DWELL - 1);
  localparam logic [GCW-1:0] GAP_LOAD   = GCW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic           d_r, d_s;
  logic [2:0]     s_r, s_s;
  logic           ov_r, ov_s;
  logic           fd_r, fd_s;
  logic [7:0]     fc_r, fc_s;
  logic [2:0]     nc_r, nc_s;
  logic [2:0]     chan_s;
  logic [DCW-1:0] dwell_r, dwell_s;
  logic [GCW-1:0] gap_r, gap_s;

  assign up.in_ready = (state_r == ST_IDLE);
  assign D          = d_r;
  assign S          = s_r;
  assign out_valid  = ov_r;
  assign frame_done = fd_r;
  assign frame_cnt  = fc_r;

  // Next-state and next-output decode
  always_comb begin
    state_s = state_r;
    d_s     = d_r;
    s_s     = s_r;
    ov_s    = ov_r;
    fd_s    = 1'b0;
    fc_s    = fc_r;
    nc_s    = nc_r;
    dwell_s = dwell_r;
    gap_s   = gap_r;
    chan_s  = up.explicit ? up.in_chan : nc_r;
    case (state_r)
      ST_IDLE: begin
        d_s  = 1'b0;
        ov_s = 1'b0;
        if (up.in_valid) begin
          d_s     = up.in_bit;
          s_s     = chan_s;
          ov_s    = 1'b1;
          dwell_s = DWELL_LOAD;
          nc_s    = chan_s + 3'd1;
          state_s = ST_DRIVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (dwell_r == {DCW{1'b0}}) begin
          d_s  = 1'b0;
          ov_s = 1'b0;
          // Frame boundary is the end of channel 7's dwell, whichever mode chose it
          if (s_r == 3'd7) begin
            fd_s = 1'b1;
            fc_s = fc_r + 8'd1;
          end else begin
            fd_s = 1'b0;
          end
          if (GAP > 0) begin
            gap_s   = GAP_LOAD;
            state_s = ST_GAP;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          dwell_s = dwell_r - DCW'(1);
        end
      end
      ST_GAP: begin
        d_s  = 1'b0;
        ov_s = 1'b0;
        if (gap_r == {GCW{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          gap_s = gap_r - GCW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        d_s     = 1'b0;
        ov_s    = 1'b0;
      end
    endcase
    // Pointer clear wins over the post-acceptance increment
    if (clr_frame) begin
      nc_s = 3'd0;
    end else begin
      nc_s = nc_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      d_r     <= 1'b0;
      s_r     <= 3'd0;
      ov_r    <= 1'b0;
      fd_r    <= 1'b0;
      fc_r    <= 8'd0;
      nc_r    <= 3'd0;
      dwell_r <= {DCW{1'b0}};
      gap_r   <= {GCW{1'b0}};
    end else begin
      state_r <= state_s;
      d_r     <= d_s;
      s_r     <= s_s;
      ov_r    <= ov_s;
      fd_r    <= fd_s;
      fc_r    <= fc_s;
      nc_r    <= nc_s;
      dwell_r <= dwell_s;
      gap_r   <= gap_s;
    end
  end

endmodule

// File: tb/tb_demux1x8_driver.sv
// Directed bench: a per-cycle vector table for the DWELL=2/GAP=1 driver plus
// hand sequences for async reset and a GAP=0 frame-counter wrap.
module tb_demux1x8_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_frame, clr_frame0;
  logic D, ov, fd, D0, ov0, fd0;
  logic [2:0] S, S0;
  logic [7:0] fc, fc0;

  demux1x8_driver_if bus ();
  demux1x8_driver_if bus0 ();

  demux1x8_driver #(.DWELL(2), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .up(bus.slave), .clr_frame(clr_frame),
    .D(D), .S(S), .out_valid(ov), .frame_done(fd), .frame_cnt(fc)
  );

  demux1x8_driver #(.DWELL(2), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .up(bus0.slave), .clr_frame(clr_frame0),
    .D(D0), .S(S0), .out_valid(ov0), .frame_done(fd0), .frame_cnt(fc0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        b;
    logic [2:0]  ich;
    logic        ex;
    logic        clr;
    logic [14:0] exp;  // {D, S, out_valid, in_ready, frame_done, frame_cnt}
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  logic [2:0] m_prev_s;
  logic [7:0] m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic iv, input logic b, input logic [2:0] ich, input logic ex,
                      input logic clr, input logic [14:0] exp);
    vec_t v;
    v.iv = iv; v.b = b; v.ich = ich; v.ex = ex; v.clr = clr; v.exp = exp;
    vecs.push_back(v);
  endtask

  // One transfer = IDLE accept cycle, two DRIVE cycles, one GAP cycle
  task automatic push_xfer(input logic b, input logic ex, input logic [2:0] ich,
                           input logic [2:0] ch, input int clr_at);
    logic fin;
    push(1'b1, b, ich, ex, clr_at == 0, {1'b0, m_prev_s, 1'b0, 1'b1, 1'b0, m_fc});
    push(1'b1, ~b, ich, ex, clr_at == 1, {b, ch, 1'b1, 1'b0, 1'b0, m_fc});
    push(1'b1, ~b, ich, ex, clr_at == 2, {b, ch, 1'b1, 1'b0, 1'b0, m_fc});
    fin = (ch == 3'd7);
    if (fin) m_fc = m_fc + 8'd1;
    push(1'b1, ~b, ich, ex, clr_at == 3, {1'b0, ch, 1'b0, 1'b0, fin, m_fc});
    m_prev_s = ch;
  endtask

  task automatic run_table();
    logic [14:0] act;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.in_valid = vecs[i].iv;
      bus.in_bit   = vecs[i].b;
      bus.in_chan  = vecs[i].ich;
      bus.explicit = vecs[i].ex;
      clr_frame    = vecs[i].clr;
      #1;
      act = {D, S, ov, bus.in_ready, fd, fc};
      checks++;
      if (act !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got D=%b S=%0d ov=%b rdy=%b fd=%b fc=%0d expected D=%b S=%0d ov=%b rdy=%b fd=%b fc=%0d",
                 i, act[14], act[13:11], act[10], act[9], act[8], act[7:0],
                 vecs[i].exp[14], vecs[i].exp[13:11], vecs[i].exp[10], vecs[i].exp[9],
                 vecs[i].exp[8], vecs[i].exp[7:0]);
      end
    end
  endtask

  initial begin
    int pulses, t1, t2, tlast;
    logic [7:0] bits;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_chan = 3'd0; bus.explicit = 1'b0;
    bus0.in_valid = 1'b0; bus0.in_bit = 1'b0; bus0.in_chan = 3'd0; bus0.explicit = 1'b0;
    clr_frame = 1'b0; clr_frame0 = 1'b0;
    rst_n = 1'b0;

    repeat (3) @(negedge clk);
    #1 check("reset_outputs", {D, S, ov, bus.in_ready, fd, fc}, {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0});
    rst_n = 1'b1;

    m_prev_s = 3'd0;
    m_fc     = 8'd0;
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0});
    bits = 8'b0100_1101;  // bit for channel k is bits[k]: 1,0,1,1,0,0,1,0
    for (int k = 0; k < 8; k++) push_xfer(bits[k], 1'b0, 3'd0, 3'(k), -1);
    // explicit channel 5, then auto continues at 6 and 7
    push_xfer(1'b1, 1'b1, 3'd5, 3'd5, -1);
    push_xfer(1'b0, 1'b0, 3'd0, 3'd6, -1);
    push_xfer(1'b1, 1'b0, 3'd0, 3'd7, -1);
    // clear mid-frame during DRIVE of channel 2, then clear on an acceptance
    push_xfer(1'b1, 1'b0, 3'd0, 3'd0, -1);
    push_xfer(1'b0, 1'b0, 3'd0, 3'd1, -1);
    push_xfer(1'b1, 1'b0, 3'd0, 3'd2, 1);
    push_xfer(1'b1, 1'b0, 3'd0, 3'd0, -1);
    push_xfer(1'b0, 1'b0, 3'd0, 3'd1, 0);
    push_xfer(1'b1, 1'b0, 3'd0, 3'd0, -1);
    run_table();

    // async reset while channel 3 is being driven
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.explicit = 1'b1; bus.in_chan = 3'd3; clr_frame = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.explicit = 1'b0;
    #1 check("pre_reset_drive", {D, S, ov, fc}, {1'b1, 3'd3, 1'b1, 8'd2});
    #2 rst_n = 1'b0;
    #1 check("async_reset", {D, S, ov, bus.in_ready, fd, fc}, {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 check("post_reset_auto", {D, S, ov}, {1'b1, 3'd0, 1'b1});

    // GAP=0 driver: 256 auto frames, period DWELL+1 = 3 cycles per transfer
    @(negedge clk);
    bus0.in_valid = 1'b1; bus0.in_bit = 1'b1;
    pulses = 0; t1 = 0; t2 = 0; tlast = 0;
    for (int cyc = 1; cyc <= 7000; cyc++) begin
      @(negedge clk);
      #1;
      if (fd0) begin
        pulses++;
        if (pulses == 1) begin
          t1 = cyc;
          check("gap0_fc_first", 32'(fc0), 32'd1);
        end
        if (pulses == 2) t2 = cyc;
        if (pulses == 256) begin
          tlast = cyc;
          break;
        end
      end
    end
    bus0.in_valid = 1'b0;
    check("gap0_pulses", 32'(pulses), 32'd256);
    check("gap0_first_frame_time", 32'(t1), 32'd24);
    check("gap0_frame_period", 32'(t2 - t1), 32'd24);
    check("gap0_last_frame_time", 32'(tlast), 32'd6144);
    check("gap0_fc_wrap", 32'(fc0), 32'd0);
    @(negedge clk);
    #1 check("gap0_fd_single", 32'(fd0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
